// File: rtl/sseg_pkg.sv
// Shared types, active-high seven-segment patterns and the digit decoder
// for the front-panel counter.
package sseg_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [6:0] seg_t;

  typedef enum logic {
    PRESS_IDLE = 1'b0,
    PRESS_HELD = 1'b1
  } press_state_e;

  // Bit order {g,f,e,d,c,b,a}, 1 = lit.
  localparam seg_t SEG_DIG0  = 7'b0111111;
  localparam seg_t SEG_DIG1  = 7'b0000110;
  localparam seg_t SEG_DIG2  = 7'b1011011;
  localparam seg_t SEG_DIG3  = 7'b1001111;
  localparam seg_t SEG_DIG4  = 7'b1100110;
  localparam seg_t SEG_DIG5  = 7'b1101101;
  localparam seg_t SEG_DIG6  = 7'b1111101;
  localparam seg_t SEG_DIG7  = 7'b0000111;
  localparam seg_t SEG_DIG8  = 7'b1111111;
  localparam seg_t SEG_DIG9  = 7'b1101111;
  localparam seg_t SEG_BLANK = 7'b0000000;

  function automatic seg_t seg_decode(input bcd_digit_t d);
    seg_t s;
    case (d)
      4'd0:    s = SEG_DIG0;
      4'd1:    s = SEG_DIG1;
      4'd2:    s = SEG_DIG2;
      4'd3:    s = SEG_DIG3;
      4'd4:    s = SEG_DIG4;
      4'd5:    s = SEG_DIG5;
      4'd6:    s = SEG_DIG6;
      4'd7:    s = SEG_DIG7;
      4'd8:    s = SEG_DIG8;
      4'd9:    s = SEG_DIG9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sseg_counter_ctrl_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for one raw input;
// the level only flips after DEBOUNCE_CYCLES consecutive differing samples.
module debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/sseg_counter_ctrl.sv
// Front-panel control: debounced button steps a BCD up/down counter that is
// decoded to seven-segment patterns. SSEG_LEADING_ZERO_BLANK_EN blanks leading zeros.
module sseg_counter_ctrl
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS      = 6,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SEG_ACTIVE_LOW  = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    button,
  input  logic                    switch,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic [7*NUM_DIGITS-1:0] ssegment,
  output logic                    wrap
);

  localparam logic                    ACT_LOW  = (SEG_ACTIVE_LOW != 0);
  localparam logic [7*NUM_DIGITS-1:0] SEG_DARK = {(7*NUM_DIGITS){ACT_LOW}};

  logic                    btn_level;
  logic                    sw_sync1_q, sw_sync2_q;
  press_state_e            state_q, state_d;
  logic                    step;
  logic [4*NUM_DIGITS-1:0] count_q, count_d, count_step;
  logic                    step_wraps;
  logic                    wrap_q, wrap_d;
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   blank;
  bcd_digit_t              digit;
  logic                    carry;
  seg_t                    pat;

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk_i  (clock),
    .rst_ni (reset),
    .raw_i  (button),
    .level_o(btn_level)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sw_sync1_q <= 1'b0;
      sw_sync2_q <= 1'b0;
    end else begin
      sw_sync1_q <= switch;
      sw_sync2_q <= sw_sync1_q;
    end
  end

  // One step per press: the pulse fires only on the IDLE->HELD transition.
  always_comb begin
    state_d = state_q;
    step    = 1'b0;
    case (state_q)
      PRESS_IDLE: begin
        if (btn_level) begin
          state_d = PRESS_HELD;
          step    = 1'b1;
        end
      end
      PRESS_HELD: begin
        if (!btn_level) begin
          state_d = PRESS_IDLE;
        end
      end
      default: state_d = PRESS_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= PRESS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Ripple a +1/-1 through the digits; a carry/borrow out of the top digit is a wrap.
  always_comb begin
    count_step = count_q;
    carry      = 1'b1;
    digit      = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      digit = count_q[4*k +: 4];
      if (carry) begin
        if (sw_sync2_q) begin
          if (digit == 4'd9) begin
            digit = 4'd0;
          end else begin
            digit = digit + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            digit = 4'd9;
          end else begin
            digit = digit - 4'd1;
            carry = 1'b0;
          end
        end
      end
      count_step[4*k +: 4] = digit;
    end
    step_wraps = carry;
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (step) begin
      count_d = count_step;
      wrap_d  = step_wraps;
    end
  end

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; zeros stay blank until the first non-zero digit.
  always_comb begin
    logic leading;
    leading = 1'b1;
    blank   = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (count_q[4*k +: 4] != 4'd0) begin
        leading = 1'b0;
      end
      blank[k] = leading;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    seg_d = SEG_DARK;
    pat   = SEG_BLANK;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      pat = blank[k] ? SEG_BLANK : seg_decode(count_q[4*k +: 4]);
      seg_d[7*k +: 7] = pat ^ {7{ACT_LOW}};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      seg_q   <= SEG_DARK;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      seg_q   <= seg_d;
    end
  end

  assign count_bcd = count_q;
  assign ssegment  = seg_q;
  assign wrap      = wrap_q;

endmodule
